// File: rtl/fp_gen_pkg.sv
// rtl/fp_gen_pkg.sv - shared rounding-mode encodings, flag struct and format helpers
package fp_gen_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RUP = 3'b010,
        RM_RDN = 3'b011,
        RM_RMM = 3'b100,
        RM_RTO = 3'b101
    } rm_e;

    typedef struct packed {
        logic inexact;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    // {exp, frac} of the largest finite magnitude, right-aligned in 64 bits
    function automatic logic [63:0] fp_max_finite(input int exp_w, input int frac_w);
        logic [63:0] e;
        logic [63:0] f;
        e = (64'd1 << exp_w) - 64'd2;
        f = (64'd1 << frac_w) - 64'd1;
        return (e << frac_w) | f;
    endfunction

endpackage

// File: rtl/fp_round_gen_if.sv
// rtl/fp_round_gen_if.sv - operand/result bundle between a datapath and the rounder
interface fp_round_gen_if #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int WI = W + 4;

    logic          ce;
    logic [2:0]    rm;
    logic          vi;
    logic [WI-1:0] i;
    logic [W-1:0]  o;
    logic          vo;
    logic          inexact;
    logic          overflow;
    logic          underflow;

    modport master (
        output ce, rm, vi, i,
        input  o, vo, inexact, overflow, underflow
    );

    modport slave (
        input  ce, rm, vi, i,
        output o, vo, inexact, overflow, underflow
    );

endinterface

// File: rtl/fp_round_bit.sv
// rtl/fp_round_bit.sv - rounding increment / force-odd / saturation decode
module fp_round_bit
    import fp_gen_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       l,
    input  logic       g,
    input  logic       r,
    input  logic       s,
    input  logic       special,
    output logic       rnd,
    output logic       force_odd,
    output logic       sat_mode
);

    logic x;

    // sat_mode marks modes that never round away here; on overflow they clamp to max-finite
    always_comb begin
        x         = g | r | s;
        rnd       = 1'b0;
        force_odd = 1'b0;
        sat_mode  = 1'b0;
        case (rm)
            RM_RTZ: sat_mode = 1'b1;
            RM_RUP: begin
                rnd      = x & ~sign;
                sat_mode = sign;
            end
            RM_RDN: begin
                rnd      = x & sign;
                sat_mode = ~sign;
            end
            RM_RMM: rnd = g;
            RM_RTO: begin
                force_odd = x;
                sat_mode  = 1'b1;
            end
            default: rnd = g & (r | s | l);
        endcase
        if (special) begin
            rnd       = 1'b0;
            force_odd = 1'b0;
        end
    end

endmodule

// File: rtl/fp_round_gen.sv
// rtl/fp_round_gen.sv - three-stage parametrised IEEE-754 rounder with exception flags
module fp_round_gen
    import fp_gen_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input logic          clk,
    input logic          rst,
    fp_round_gen_if.slave bus
);

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int WI = W + 4;
    localparam int EF = EXP_W + FRAC_W;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_SAT  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EF-1:0]    MAX_FIN  = EF'(fp_max_finite(EXP_W, FRAC_W));

    logic              in_sign, in_hid, in_special;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W-1:0] in_frac;
    logic              dec_rnd, dec_force, dec_sat;

    assign in_sign    = bus.i[WI-1];
    assign in_exp     = bus.i[WI-2 -: EXP_W];
    assign in_hid     = bus.i[FRAC_W+3];
    assign in_frac    = bus.i[FRAC_W+2:3];
    assign in_special = &in_exp;

    fp_round_bit u_round_bit (
        .rm        (bus.rm),
        .sign      (in_sign),
        .l         (in_frac[0]),
        .g         (bus.i[2]),
        .r         (bus.i[1]),
        .s         (bus.i[0]),
        .special   (in_special),
        .rnd       (dec_rnd),
        .force_odd (dec_force),
        .sat_mode  (dec_sat)
    );

    // stage 1
    logic              v1_d, v1_q, sign1_d, sign1_q, rnd1_d, rnd1_q, force1_d, force1_q;
    logic              sat1_d, sat1_q, inexact1_d, inexact1_q, special1_d, special1_q;
    logic [EXP_W-1:0]  exp1_d, exp1_q;
    logic [FRAC_W-1:0] frac1_d, frac1_q;

    always_comb begin
        v1_d       = bus.vi;
        sign1_d    = in_sign;
        // hidden bit set with a zero exponent is the smallest normal binade
        exp1_d     = (in_exp == '0 && in_hid) ? EXP_ONE : in_exp;
        frac1_d    = in_frac;
        rnd1_d     = dec_rnd;
        force1_d   = dec_force;
        sat1_d     = dec_sat;
        inexact1_d = (|bus.i[2:0]) & ~in_special;
        special1_d = in_special;
    end

    // stage 2
    logic           v2_d, v2_q, sign2_d, sign2_q, sat2_d, sat2_q;
    logic           inexact2_d, inexact2_q, ovf2_d, ovf2_q;
    logic [EF-1:0]  sum2_d, sum2_q;
    logic [EF:0]    sum;
    logic           near_max;

    always_comb begin
        sum        = {1'b0, exp1_q, frac1_q} + (EF+1)'(rnd1_q);
        near_max   = (exp1_q == EXP_SAT) && (&frac1_q);
        v2_d       = v1_q;
        sign2_d    = sign1_q;
        sat2_d     = sat1_q;
        inexact2_d = inexact1_q;
        sum2_d     = {sum[EF-1:1], sum[0] | force1_q};
        // truncating modes still report overflow when the exact value exceeds max-finite
        ovf2_d     = (~special1_q & (sum[EF] | (sum[EF-1 -: EXP_W] == EXP_ONES)))
                   | (sat1_q & inexact1_q & near_max);
    end

    // stage 3
    logic            vo_d, vo_q;
    logic [W-1:0]    o_d, o_q;
    fp_flags_t       flags_d, flags_q;

    always_comb begin
        if (ovf2_q) begin
            o_d = sat2_q ? {sign2_q, MAX_FIN} : {sign2_q, EXP_ONES, {FRAC_W{1'b0}}};
        end else begin
            o_d = {sign2_q, sum2_q};
        end
        vo_d              = v2_q;
        flags_d.inexact   = v2_q & inexact2_q;
        flags_d.overflow  = v2_q & ovf2_q;
        flags_d.underflow = v2_q & inexact2_q & (o_d[W-2 -: EXP_W] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            sign1_q    <= 1'b0;
            exp1_q     <= '0;
            frac1_q    <= '0;
            rnd1_q     <= 1'b0;
            force1_q   <= 1'b0;
            sat1_q     <= 1'b0;
            inexact1_q <= 1'b0;
            special1_q <= 1'b0;
            v2_q       <= 1'b0;
            sign2_q    <= 1'b0;
            sat2_q     <= 1'b0;
            inexact2_q <= 1'b0;
            ovf2_q     <= 1'b0;
            sum2_q     <= '0;
            vo_q       <= 1'b0;
            o_q        <= '0;
            flags_q    <= '0;
        end else if (bus.ce) begin
            v1_q       <= v1_d;
            sign1_q    <= sign1_d;
            exp1_q     <= exp1_d;
            frac1_q    <= frac1_d;
            rnd1_q     <= rnd1_d;
            force1_q   <= force1_d;
            sat1_q     <= sat1_d;
            inexact1_q <= inexact1_d;
            special1_q <= special1_d;
            v2_q       <= v2_d;
            sign2_q    <= sign2_d;
            sat2_q     <= sat2_d;
            inexact2_q <= inexact2_d;
            ovf2_q     <= ovf2_d;
            sum2_q     <= sum2_d;
            vo_q       <= vo_d;
            o_q        <= o_d;
            flags_q    <= flags_d;
        end
    end

    assign bus.o         = o_q;
    assign bus.vo        = vo_q;
    assign bus.inexact   = flags_q.inexact;
    assign bus.overflow  = flags_q.overflow;
    assign bus.underflow = flags_q.underflow;

endmodule

// File: tb/tb_fp_round_gen.sv
// tb/tb_fp_round_gen.sv - scoreboard bench for fp_round_gen in binary32 format
module tb_fp_round_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_round_gen_if #(.EXP_W(8), .FRAC_W(23)) bus ();

    fp_round_gen #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] o;
        logic [2:0]  fl;
        int          due;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ce_cnt = 0;
    int   n_sent = 0;
    logic last_ce = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    function automatic logic [35:0] mk(input logic sgn, input logic [7:0] e, input logic h,
                                       input logic [22:0] f, input logic [2:0] grs);
        return {sgn, e, h, f, grs};
    endfunction

    always @(posedge clk) begin
        last_ce <= bus.ce;
        if (!rst && bus.ce) ce_cnt <= ce_cnt + 1;
    end

    always @(negedge clk) begin
        if (!rst && last_ce && bus.vo) begin
            if (sb.size() == 0) begin
                chk("unexpected_vo", 64'(bus.vo), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("o%0d", e.id), 64'(bus.o), 64'(e.o));
                chk($sformatf("flags%0d", e.id),
                    64'({bus.inexact, bus.overflow, bus.underflow}), 64'(e.fl));
                chk($sformatf("latency%0d", e.id), 64'(ce_cnt), 64'(e.due));
            end
        end
    end

    task automatic send(input logic [2:0] m, input logic [35:0] vin,
                        input logic [31:0] eo, input logic [2:0] efl);
        exp_t e;
        bus.rm = m;
        bus.i  = vin;
        bus.vi = 1'b1;
        e.o   = eo;
        e.fl  = efl;
        e.due = ce_cnt + 3;
        e.id  = n_sent;
        n_sent++;
        sb.push_back(e);
        @(negedge clk);
        bus.vi = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus.ce = 1'b1;
        bus.rm = 3'b000;
        bus.vi = 1'b0;
        bus.i  = '0;
        repeat (3) @(negedge clk);
        chk("reset_vo", 64'(bus.vo), 64'd0);
        chk("reset_o", 64'(bus.o), 64'd0);
        chk("reset_flags", 64'({bus.inexact, bus.overflow, bus.underflow}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // flags are {inexact, overflow, underflow}
        send(3'b000, mk(0, 8'h7F, 1, 23'h000001, 3'b100), 32'h3F800002, 3'b100);
        send(3'b000, mk(0, 8'h7F, 1, 23'h000000, 3'b100), 32'h3F800000, 3'b100);
        send(3'b000, mk(0, 8'h7E, 1, 23'h7FFFFF, 3'b110), 32'h3F800000, 3'b100);
        send(3'b000, mk(0, 8'hFE, 1, 23'h7FFFFF, 3'b100), 32'h7F800000, 3'b110);
        send(3'b001, mk(0, 8'hFE, 1, 23'h7FFFFF, 3'b100), 32'h7F7FFFFF, 3'b110);
        send(3'b010, mk(1, 8'hFE, 1, 23'h7FFFFF, 3'b100), 32'hFF7FFFFF, 3'b110);
        send(3'b000, mk(0, 8'h00, 0, 23'h7FFFFF, 3'b110), 32'h00800000, 3'b100);
        send(3'b000, mk(0, 8'h00, 0, 23'h000001, 3'b010), 32'h00000001, 3'b101);
        send(3'b101, mk(0, 8'h7F, 1, 23'h000000, 3'b001), 32'h3F800001, 3'b100);
        send(3'b000, mk(0, 8'hFF, 1, 23'h400000, 3'b111), 32'h7FC00000, 3'b000);
        bus.i = '0;
        @(negedge clk);
        send(3'b100, mk(0, 8'h7F, 1, 23'h000000, 3'b100), 32'h3F800001, 3'b100);
        send(3'b010, mk(0, 8'h7F, 1, 23'h000000, 3'b001), 32'h3F800001, 3'b100);
        send(3'b011, mk(0, 8'h7F, 1, 23'h000000, 3'b001), 32'h3F800000, 3'b100);
        send(3'b011, mk(1, 8'h7F, 1, 23'h000000, 3'b001), 32'hBF800001, 3'b100);
        send(3'b110, mk(0, 8'h7F, 1, 23'h000001, 3'b100), 32'h3F800002, 3'b100);
        send(3'b000, mk(0, 8'h40, 1, 23'h123456, 3'b000), 32'h20123456, 3'b000);
        send(3'b011, mk(1, 8'hFE, 1, 23'h7FFFFF, 3'b100), 32'hFF800000, 3'b110);
        send(3'b101, mk(1, 8'hFE, 1, 23'h7FFFFF, 3'b010), 32'hFF7FFFFF, 3'b110);
        send(3'b000, mk(0, 8'hFE, 1, 23'h7FFFFF, 3'b010), 32'h7F7FFFFF, 3'b100);
        drain();

        send(3'b000, mk(0, 8'h7F, 1, 23'h000001, 3'b100), 32'h3F800002, 3'b100);
        bus.ce = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_vo", 64'(bus.vo), 64'd0);
        bus.ce = 1'b1;
        drain();

        send(3'b100, mk(0, 8'h7F, 1, 23'h000000, 3'b100), 32'h3F800001, 3'b100);
        drain();
        send(3'b000, mk(0, 8'h7E, 1, 23'h7FFFFF, 3'b110), 32'h3F800000, 3'b100);
        #2 rst = 1'b1;
        #1;
        chk("midrst_vo", 64'(bus.vo), 64'd0);
        chk("midrst_o", 64'(bus.o), 64'd0);
        chk("midrst_flags", 64'({bus.inexact, bus.overflow, bus.underflow}), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_vo", 64'(bus.vo), 64'd0);

        send(3'b000, mk(0, 8'h00, 0, 23'h000001, 3'b010), 32'h00000001, 3'b101);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
